// File: rtl/kbd_ascii_fifo_if.sv
// Keyboard ASCII FIFO bus: decoder push side, CPU show-ahead read side,
// and status/overflow reporting. The master modport is the side that
// drives keys and pops (decoder + CPU); the slave modport is the FIFO.
interface kbd_ascii_fifo_if #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
);
    logic          new_key;
    logic [7:0]    ascii_key;
    logic          rd_en;
    logic          ovf_clr;
    logic [7:0]    rd_data;
    logic          empty;
    logic          full;
    logic [AW:0]   count;
    logic          overflow;
    logic [7:0]    drop_cnt;

    modport master (
        output new_key,
        output ascii_key,
        output rd_en,
        output ovf_clr,
        input  rd_data,
        input  empty,
        input  full,
        input  count,
        input  overflow,
        input  drop_cnt
    );

    modport slave (
        input  new_key,
        input  ascii_key,
        input  rd_en,
        input  ovf_clr,
        output rd_data,
        output empty,
        output full,
        output count,
        output overflow,
        output drop_cnt
    );
endinterface

// File: rtl/kbd_ascii_fifo.sv
// kbd_ascii_fifo: buffers ASCII characters from the keyboard decoder for
// MMIO reads by the CPU. Zero codes are discarded, pushes into a full FIFO
// are dropped and flagged with a sticky overflow bit.
// Read port is show-ahead: rd_data always shows the head (0 when empty).
// Optional feature macro: KBD_FIFO_DROP_CNT_EN builds a saturating 8-bit
// dropped-character counter; without it drop_cnt reads as zero.
module kbd_ascii_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic                  clk,
    input  logic                  clr,
    kbd_ascii_fifo_if.slave       bus
);

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    // Storage and pointers
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;
    logic          overflow_q, overflow_d;

    // Request decode
    logic          empty;
    logic          full;
    logic          push_req;
    logic          pop_req;
    logic          push_ok;
    logic          drop;
    logic          mem_we;

    assign empty    = (count_q == '0);
    assign full     = (count_q == FULL_CNT);
    assign push_req = bus.new_key & (bus.ascii_key != 8'h00);
    assign pop_req  = bus.rd_en & ~empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok  = push_req & (~full | pop_req);
    assign drop     = push_req & full & ~pop_req;
    assign mem_we   = push_ok & ~clr;

    // Next-state for pointers, occupancy and the sticky overflow flag
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_req) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        unique case ({push_ok, pop_req})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // A new drop takes priority over a coincident clear request.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (bus.ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    // Control registers with synchronous reset
    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Character storage; contents survive reset, a push during reset is discarded
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= bus.ascii_key;
        end
    end

`ifdef KBD_FIFO_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    // Saturating drop counter; a drop coinciding with a clear restarts at one
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (bus.ovf_clr) begin
            drop_cnt_d = drop ? 8'h01 : 8'h00;
        end else if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'h01;
        end
    end

    // Drop counter register
    always_ff @(posedge clk) begin
        if (clr) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign bus.drop_cnt = drop_cnt_q;
`else
    assign bus.drop_cnt = '0;
`endif

    // Output mapping; head byte is masked while the FIFO holds nothing
    assign bus.rd_data  = empty ? 8'h00 : mem_q[rd_ptr_q];
    assign bus.empty    = empty;
    assign bus.full     = full;
    assign bus.count    = count_q;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_kbd_ascii_fifo.sv
// Testbench for kbd_ascii_fifo: directed scenarios followed by random
// traffic. The driver updates a queue-based reference model as it issues
// each cycle; a negedge monitor pops expected characters and compares.
module tb_kbd_ascii_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic clk;
    logic clr;

    kbd_ascii_fifo_if #(.DEPTH(DEPTH), .AW(AW)) bus ();

    kbd_ascii_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model
    logic [7:0] exp_q[$];
    bit         m_valid;
    bit         m_ovf;
    int         m_drop;

    // Expected DUT state for the current cycle (before its posedge)
    bit         exp_chk;
    int         exp_count;
    bit         exp_ovf;
    int         exp_drop;
    int         exp_head;
    bit         exp_pop;

    int n_cmp;
    int n_bad;

    function automatic void chk(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endfunction

    // Monitor: status is compared every cycle; head pops from the scoreboard
    always @(negedge clk) begin
        if (exp_chk) begin
            chk("count",    int'(bus.count),    exp_count);
            chk("empty",    int'(bus.empty),    (exp_count == 0) ? 1 : 0);
            chk("full",     int'(bus.full),     (exp_count == DEPTH) ? 1 : 0);
            chk("overflow", int'(bus.overflow), int'(exp_ovf));
            chk("drop_cnt", int'(bus.drop_cnt), exp_drop);
            if (exp_pop) begin
                if (exp_q.size() == 0) begin
                    chk("scoreboard_underflow", 1, 0);
                end else begin
                    chk("rd_data_pop", int'(bus.rd_data), int'(exp_q.pop_front()));
                end
            end else begin
                chk("rd_data", int'(bus.rd_data), exp_head);
            end
        end
    end

    // Issue one cycle of stimulus and advance the model to match
    task automatic cyc(input bit c, input bit nk, input logic [7:0] k,
                       input bit re, input bit oc);
        bit pop;
        bit push;
        bit drop;
        @(posedge clk);
        #1;
        clr           = c;
        bus.new_key   = nk;
        bus.ascii_key = k;
        bus.rd_en     = re;
        bus.ovf_clr   = oc;

        exp_chk   = m_valid;
        exp_count = exp_q.size();
        exp_ovf   = m_ovf;
        exp_drop  = m_drop;
        exp_head  = (exp_q.size() > 0) ? int'(exp_q[0]) : 0;
        exp_pop   = 1'b0;

        if (c) begin
            exp_q.delete();
            m_ovf   = 1'b0;
            m_drop  = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            pop  = re && (exp_q.size() > 0);
            push = nk && (k != 8'h00);
            drop = push && (exp_q.size() == DEPTH) && !pop;
            exp_pop = pop;
            if (push && !drop) exp_q.push_back(k);
            if (drop) m_ovf = 1'b1;
            else if (oc) m_ovf = 1'b0;
`ifdef KBD_FIFO_DROP_CNT_EN
            if (oc) m_drop = drop ? 1 : 0;
            else if (drop && m_drop < 255) m_drop = m_drop + 1;
`endif
        end
    endtask

    task automatic idle();
        cyc(0, 0, 8'h00, 0, 0);
    endtask

    task automatic push(input logic [7:0] k);
        cyc(0, 1, k, 0, 0);
    endtask

    task automatic pop();
        cyc(0, 0, 8'h00, 1, 0);
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_drop  = 0;
        exp_chk = 1'b0;
        exp_pop = 1'b0;
        clr           = 1'b1;
        bus.new_key   = 1'b0;
        bus.ascii_key = 8'h00;
        bus.rd_en     = 1'b0;
        bus.ovf_clr   = 1'b0;

        // Reset
        cyc(1, 0, 8'h00, 0, 0);
        cyc(1, 0, 8'h00, 0, 0);
        idle();

        // Basic order
        push(8'h41); push(8'h62); push(8'h31);
        pop(); pop(); pop();
        idle();

        // Zero code ignored, pop on empty harmless
        cyc(0, 1, 8'h00, 0, 0);
        pop();
        idle();

        // Fill, overflow, drain
        for (int i = 1; i <= DEPTH; i++) push(8'(i));
        push(8'h11);
        idle();
        for (int i = 0; i < DEPTH; i++) pop();
        idle();
        cyc(0, 0, 8'h00, 0, 1);
        idle();

        // Full with simultaneous push and pop
        for (int i = 1; i <= DEPTH; i++) push(8'(i + 8'h60));
        cyc(0, 1, 8'h20, 1, 0);
        idle();
        for (int i = 0; i < DEPTH; i++) pop();
        idle();

        // Wrap: push/pop pairs keep ordering across pointer wrap
        push(8'h70);
        for (int i = 0; i < 40; i++) cyc(0, 1, 8'(8'h80 + i), 1, 0);
        pop();
        idle();

        // Empty with push and rd_en together
        cyc(0, 1, 8'h55, 1, 0);
        idle();
        pop();

        // Reset in the middle of a push burst
        push(8'h01); push(8'h02); push(8'h03);
        cyc(1, 1, 8'h04, 0, 0);
        push(8'h05); push(8'h06);
        idle();
        pop(); pop();

        // Sustained drops: counter saturation and clear/drop coincidence
        for (int i = 1; i <= DEPTH; i++) push(8'(i + 8'h30));
        for (int i = 0; i < 300; i++) push(8'hEE);
        idle();
        cyc(0, 1, 8'hEF, 0, 1);
        idle();
        cyc(0, 0, 8'h00, 0, 1);
        cyc(1, 0, 8'h00, 0, 0);
        idle();

        // Random traffic with alternating fill/drain bias
        for (int i = 0; i < 3000; i++) begin
            bit         nk;
            bit         re;
            bit         oc;
            bit         c;
            logic [7:0] k;
            int         phase;
            phase = (i / 200) % 3;
            nk = ($urandom_range(0, 3) < ((phase == 0) ? 3 : (phase == 1) ? 1 : 2));
            re = ($urandom_range(0, 3) < ((phase == 0) ? 1 : (phase == 1) ? 3 : 2));
            k  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            oc = ($urandom_range(0, 31) == 0);
            c  = ($urandom_range(0, 499) == 0);
            cyc(c, nk, k, re, oc);
        end

        idle();
        idle();
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
